// File: rtl/voq_queue_buffer.sv
// Virtual output queue buffer: one register-array FIFO per destination port, with
// registered almost-full backpressure, one-cycle registered read ports and a drop counter.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module voq_queue_buffer #(
   parameter int unsigned PORT_NUB   = `PORT_NUB_TOTAL,
   parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AF_LEVEL   = DEPTH - 2,
   localparam int unsigned WIDTH_SEL  = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1,
   localparam int unsigned WIDTH_PORT = WIDTH_SEL + DATA_WIDTH,
   localparam int unsigned WIDTH_CNT  = $clog2(DEPTH) + 1,
   localparam int unsigned WIDTH_PTR  = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           valid_in,
   input  logic [WIDTH_PORT-1:0]          data_in,
   output logic                           voq_full_out,
   input  logic [PORT_NUB-1:0]            rd_req,
   output logic [PORT_NUB-1:0]            rd_valid,
   output logic [PORT_NUB*DATA_WIDTH-1:0] rd_data,
   output logic [PORT_NUB-1:0]            q_empty,
   output logic [15:0]                    drop_cnt
);

   logic [WIDTH_SEL-1:0]  wr_sel;
   logic [DATA_WIDTH-1:0] wr_payload;

   logic [DATA_WIDTH-1:0] mem_q    [PORT_NUB][DEPTH];
   logic [WIDTH_PTR-1:0]  wr_ptr_q [PORT_NUB];
   logic [WIDTH_PTR-1:0]  rd_ptr_q [PORT_NUB];
   logic [WIDTH_CNT-1:0]  cnt_q    [PORT_NUB];

   logic [PORT_NUB-1:0] wr_en;
   logic [PORT_NUB-1:0] rd_en;
   logic [PORT_NUB-1:0] af_hit;
   logic                drop;

   assign wr_sel     = data_in[WIDTH_PORT-1:DATA_WIDTH];
   assign wr_payload = data_in[DATA_WIDTH-1:0];

   // Full/empty decisions use the pre-cycle count, so a pop never frees room for a
   // same-cycle push into a full queue.
   always_comb begin
      wr_en   = '0;
      rd_en   = '0;
      af_hit  = '0;
      q_empty = '0;
      for (int unsigned q = 0; q < PORT_NUB; q++) begin
         wr_en[q]   = valid_in && (32'(wr_sel) == q) && (cnt_q[q] != WIDTH_CNT'(DEPTH));
         rd_en[q]   = rd_req[q] && (cnt_q[q] != '0);
         af_hit[q]  = (cnt_q[q] >= WIDTH_CNT'(AF_LEVEL));
         q_empty[q] = (cnt_q[q] == '0);
      end
      drop = valid_in && (wr_en == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned q = 0; q < PORT_NUB; q++) begin
            wr_ptr_q[q] <= '0;
            rd_ptr_q[q] <= '0;
            cnt_q[q]    <= '0;
         end
         rd_valid     <= '0;
         rd_data      <= '0;
         voq_full_out <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         for (int unsigned q = 0; q < PORT_NUB; q++) begin
            if (wr_en[q]) begin
               wr_ptr_q[q] <= wr_ptr_q[q] + WIDTH_PTR'(1);
            end
            if (rd_en[q]) begin
               rd_ptr_q[q]                        <= rd_ptr_q[q] + WIDTH_PTR'(1);
               rd_data[q*DATA_WIDTH +: DATA_WIDTH] <= mem_q[q][rd_ptr_q[q]];
            end
            if (wr_en[q] && !rd_en[q]) begin
               cnt_q[q] <= cnt_q[q] + WIDTH_CNT'(1);
            end else if (!wr_en[q] && rd_en[q]) begin
               cnt_q[q] <= cnt_q[q] - WIDTH_CNT'(1);
            end
         end
         rd_valid     <= rd_en;
         voq_full_out <= |af_hit;
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Payload storage carries no reset; validity is tracked by the pointers and counts.
   always_ff @(posedge clk) begin
      for (int unsigned q = 0; q < PORT_NUB; q++) begin
         if (wr_en[q]) begin
            mem_q[q][wr_ptr_q[q]] <= wr_payload;
         end
      end
   end

endmodule

// File: tb/tb_voq_queue_buffer.sv
// Directed self-checking bench for voq_queue_buffer (4 queues, depth 16, 8-bit payload).
module tb_voq_queue_buffer;

   localparam int unsigned PN = 4;
   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst_n;
   logic          valid_in;
   logic [9:0]    data_in;
   logic          voq_full_out;
   logic [PN-1:0] rd_req;
   logic [PN-1:0] rd_valid;
   logic [PN*DW-1:0] rd_data;
   logic [PN-1:0] q_empty;
   logic [15:0]   drop_cnt;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_b;

   voq_queue_buffer #(
      .PORT_NUB   (PN),
      .DATA_WIDTH (DW),
      .DEPTH      (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_in     (valid_in),
      .data_in      (data_in),
      .voq_full_out (voq_full_out),
      .rd_req       (rd_req),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .q_empty      (q_empty),
      .drop_cnt     (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, take the rising edge, return 1 time unit after it.
   task automatic cycle(input logic wv, input logic [1:0] sel, input logic [7:0] pl,
                        input logic [3:0] req);
      valid_in = wv;
      data_in  = {sel, pl};
      rd_req   = req;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      rd_req   = '0;
   endtask

   task automatic pop_check(input string tag, input int q, input logic [7:0] exp);
      cycle(1'b0, 2'd0, 8'h00, 4'(1 << q));
      check({tag, "_valid"}, 32'(rd_valid[q]), 32'd1);
      check({tag, "_data"}, 32'(rd_data[q*DW +: DW]), 32'(exp));
   endtask

   initial begin
      rst_n    = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      rd_req   = '0;
      #3;
      check("rst_full", 32'(voq_full_out), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_empty", 32'(q_empty), 32'hF);
      check("rst_valid", 32'(rd_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic FIFO on queue 2.
      cycle(1'b1, 2'd2, 8'h11, 4'b0000);
      cycle(1'b1, 2'd2, 8'h22, 4'b0000);
      cycle(1'b1, 2'd2, 8'h33, 4'b0000);
      check("q2_loaded_empty", 32'(q_empty), 32'hB);
      pop_check("q2_pop0", 2, 8'h11);
      pop_check("q2_pop1", 2, 8'h22);
      pop_check("q2_pop2", 2, 8'h33);
      check("q2_drained", 32'(q_empty[2]), 32'd1);
      cycle(1'b0, 2'd0, 8'h00, 4'b0000);
      check("q2_idle_valid", 32'(rd_valid), 32'd0);
      check("q2_hold_data", 32'(rd_data[2*DW +: DW]), 32'h33);

      // Pops on all-empty queues are ignored.
      cycle(1'b0, 2'd0, 8'h00, 4'b1111);
      check("empty_pop_valid", 32'(rd_valid), 32'd0);
      check("empty_pop_drop", 32'(drop_cnt), 32'd0);
      cycle(1'b1, 2'd2, 8'h77, 4'b0000);
      pop_check("empty_pop_ptr", 2, 8'h77);

      // Almost-full threshold and full drop on queue 0.
      for (int i = 0; i < 13; i++) cycle(1'b1, 2'd0, 8'(8'h40 + i), 4'b0000);
      cycle(1'b0, 2'd0, 8'h00, 4'b0000);
      check("af_at13", 32'(voq_full_out), 32'd0);
      cycle(1'b1, 2'd0, 8'h4D, 4'b0000);
      cycle(1'b0, 2'd0, 8'h00, 4'b0000);
      check("af_at14", 32'(voq_full_out), 32'd1);
      cycle(1'b1, 2'd0, 8'h4E, 4'b0000);
      cycle(1'b1, 2'd0, 8'h4F, 4'b0000);
      check("af_absorb_drop", 32'(drop_cnt), 32'd0);
      cycle(1'b1, 2'd0, 8'hEE, 4'b0000);
      check("full_drop", 32'(drop_cnt), 32'd1);
      for (int i = 0; i < 16; i++) pop_check("q0_drain", 0, 8'(8'h40 + i));
      check("q0_empty", 32'(q_empty), 32'hF);
      cycle(1'b0, 2'd0, 8'h00, 4'b0000);
      check("af_release", 32'(voq_full_out), 32'd0);

      // Steady push+pop on queue 1 at count 8, wrapping the pointers.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 2'd1, 8'(8'h80 + i), 4'b0000);
         exp_q.push_back(8'(8'h80 + i));
      end
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 2'd1, 8'(8'h90 + i), 4'b0010);
         exp_b = exp_q.pop_front();
         exp_q.push_back(8'(8'h90 + i));
         check("q1_stream_valid", 32'(rd_valid[1]), 32'd1);
         check("q1_stream_data", 32'(rd_data[1*DW +: DW]), 32'(exp_b));
      end
      check("q1_stream_drop", 32'(drop_cnt), 32'd1);
      for (int i = 0; i < 8; i++) begin
         exp_b = exp_q.pop_front();
         pop_check("q1_drain", 1, exp_b);
      end
      check("q1_empty", 32'(q_empty[1]), 32'd1);

      // Queue 3 full: same-cycle push and pop drops the push.
      for (int i = 0; i < 16; i++) cycle(1'b1, 2'd3, 8'(8'hA0 + i), 4'b0000);
      check("q3_full_drop", 32'(drop_cnt), 32'd1);
      cycle(1'b1, 2'd3, 8'hFF, 4'b1000);
      check("q3_rw_valid", 32'(rd_valid[3]), 32'd1);
      check("q3_rw_data", 32'(rd_data[3*DW +: DW]), 32'hA0);
      check("q3_rw_drop", 32'(drop_cnt), 32'd2);
      for (int i = 1; i < 16; i++) pop_check("q3_drain", 3, 8'(8'hA0 + i));
      check("q3_empty", 32'(q_empty[3]), 32'd1);

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 5; i++) cycle(1'b1, 2'd0, 8'(8'h01 + i), 4'b0000);
      pop_check("pre_rst", 0, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(rd_valid), 32'd0);
      check("arst_data", rd_data, 32'd0);
      check("arst_drop", 32'(drop_cnt), 32'd0);
      check("arst_full", 32'(voq_full_out), 32'd0);
      check("arst_empty", 32'(q_empty), 32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 2'd0, 8'h5A, 4'b0001);
      check("post_rst_pop", 32'(rd_valid[0]), 32'd0);
      pop_check("post_rst_first_wr", 0, 8'h5A);
      check("post_rst_empty", 32'(q_empty), 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
